// File: rtl/can_pkg.sv
// Shared definitions for the CAN controller CPU bus interface: register map,
// bus-controller state encoding and receive-group range helpers.
package can_pkg;

  // Receive frame group (read-only to the CPU, owned by the CAN core on grant)
  localparam logic [4:0] ADDR_RX_ID_HI  = 5'd0;
  localparam logic [4:0] ADDR_RX_ID_LO  = 5'd1;
  localparam logic [4:0] ADDR_RX_DLC    = 5'd2;
  localparam logic [4:0] ADDR_RX_DATA0  = 5'd3;
  localparam logic [4:0] ADDR_RX_DATA1  = 5'd4;
  localparam logic [4:0] ADDR_RX_DATA2  = 5'd5;
  localparam logic [4:0] ADDR_RX_DATA3  = 5'd6;
  // Transmit frame group
  localparam logic [4:0] ADDR_TX_ID_HI  = 5'd7;
  localparam logic [4:0] ADDR_TX_ID_LO  = 5'd8;
  localparam logic [4:0] ADDR_TX_DLC    = 5'd9;
  localparam logic [4:0] ADDR_TX_DATA0  = 5'd10;
  localparam logic [4:0] ADDR_TX_DATA1  = 5'd11;
  localparam logic [4:0] ADDR_TX_DATA2  = 5'd12;
  localparam logic [4:0] ADDR_TX_DATA3  = 5'd13;
  // Control and status
  localparam logic [4:0] ADDR_MODE      = 5'd14;
  localparam logic [4:0] ADDR_BTR0      = 5'd15;
  localparam logic [4:0] ADDR_BTR1      = 5'd16;
  localparam logic [4:0] ADDR_CMD       = 5'd17;
  localparam logic [4:0] ADDR_INTR      = 5'd18;
  localparam logic [4:0] ADDR_STATUS    = 5'd19;
  localparam logic [4:0] ADDR_ERR_CNT   = 5'd20;

  localparam logic [4:0] RX_FIRST = ADDR_RX_ID_HI;
  localparam logic [4:0] RX_LAST  = ADDR_RX_DATA3;
  localparam logic [4:0] ADDR_MAX = ADDR_ERR_CNT;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Address belongs to the receive group shared with the CAN core.
  // RX_FIRST is zero, so only the upper bound needs comparing.
  function automatic logic is_rx(input logic [4:0] addr);
    return addr <= RX_LAST;
  endfunction

  // Address is a CPU-writable register (transmit group through interrupt).
  function automatic logic is_writable(input logic [4:0] addr);
    return (addr > RX_LAST) && (addr < ADDR_STATUS);
  endfunction

endpackage

// File: rtl/can_rx_arbiter.sv
// Grant logic for the receive register group: the CAN core gets the group
// whenever it asks, except that a CPU access already in its ACCESS cycle to
// the receive group is allowed to finish first.
module can_rx_arbiter
  import can_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       core_req,
  input  state_t     state,
  input  logic [4:0] addr,
  output logic       core_gnt
);

  logic cpu_busy_rx;

  assign cpu_busy_rx = (state == ST_ACCESS) && is_rx(addr);

  // Grant register: holds while requested, rises only when the CPU is not mid-capture.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      core_gnt <= 1'b0;
    end else if (core_gnt) begin
      core_gnt <= core_req;
    end else begin
      core_gnt <= core_req && !cpu_busy_rx;
    end
  end

endmodule

// File: rtl/can_bus_ctrl.sv
// CPU-side bus controller for the CAN register file. Sequences each CPU access
// through IDLE/CHECK/WAIT/ACCESS/DONE, drives the read-mux address, captures
// read data, issues one-hot write strobes and defers receive-group accesses
// while the CAN core owns that group.
// Optional feature: define CAN_BUS_TIMEOUT_EN to bound WAIT to TIMEOUT_CYCLES.
module can_bus_ctrl
  import can_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_cs,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [4:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  output logic [4:0]  mux_address,
  input  logic [15:0] mux_data,
  output logic [20:0] reg_we,
  output logic [15:0] reg_wdata,
  output logic        intr_rd,
  input  logic        core_req,
  output logic        core_gnt
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("can_bus_ctrl: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t      state, state_next;
  logic [4:0]  addr_q;
  logic [15:0] wdata_q;
  logic        wr_q;
  logic        start;

  // A request with both directions asserted is malformed and never starts.
  assign start = cpu_cs && (cpu_rd ^ cpu_wr);

`ifdef CAN_BUS_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;

  // Counts cycles spent in WAIT; restarts from zero on every entry.
  always_ff @(posedge clock) begin
    if (reset || state != ST_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decision.
  always_comb begin
    // NOTE: defaulting every combinational output first means no path can infer a latch.
    state_next = state;
    unique case (state)
      ST_IDLE:   if (start) state_next = ST_CHECK;
      ST_CHECK:  state_next = (is_rx(addr_q) && core_gnt) ? ST_WAIT : ST_ACCESS;
      ST_WAIT: begin
        if (!core_gnt) begin
          state_next = ST_ACCESS;
        end
`ifdef CAN_BUS_TIMEOUT_EN
        else if (wait_cnt == WAIT_LAST) begin
          state_next = ST_DONE;
        end
`endif
      end
      ST_ACCESS: state_next = ST_DONE;
      ST_DONE:   if (!cpu_cs) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Request latch, read-data capture and error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      cpu_rdata <= '0;
      cpu_err   <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        wr_q    <= cpu_wr;
      end
      if (state == ST_ACCESS) begin
        if (!wr_q) begin
          cpu_rdata <= (addr_q > ADDR_MAX) ? 16'h0000 : mux_data;
        end
        cpu_err <= wr_q && !is_writable(addr_q);
      end
      // Abandoning WAIT straight to DONE only happens on a timeout.
      if (state == ST_WAIT && state_next == ST_DONE) begin
        cpu_rdata <= 16'h0000;
        cpu_err   <= 1'b1;
      end
      if (state == ST_DONE && !cpu_cs) begin
        cpu_err <= 1'b0;
      end
    end
  end

  // One-hot write strobe, only during ACCESS and only for writable registers.
  always_comb begin
    reg_we = '0;
    if (state == ST_ACCESS && wr_q && is_writable(addr_q)) begin
      reg_we[addr_q] = 1'b1;
    end
  end

  assign cpu_ready   = (state == ST_DONE);
  assign intr_rd     = (state == ST_ACCESS) && !wr_q && (addr_q == ADDR_INTR);
  assign mux_address = addr_q;
  assign reg_wdata   = wdata_q;

  can_rx_arbiter u_rx_arbiter (
    .clock    (clock),
    .reset    (reset),
    .core_req (core_req),
    .state    (state),
    .addr     (addr_q),
    .core_gnt (core_gnt)
  );

endmodule

// File: tb/tb_can_bus_ctrl.sv
// Self-checking bench for can_bus_ctrl: directed scenarios plus randomized
// accesses compared against a transaction-level model of the register map.
module tb_can_bus_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_cs, cpu_rd, cpu_wr;
  logic [4:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ready, cpu_err;
  logic [4:0]  mux_address;
  logic [15:0] mux_data;
  logic [20:0] reg_we;
  logic [15:0] reg_wdata;
  logic        intr_rd;
  logic        core_req, core_gnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Register file contents seen through the read mux; entries above 20 are junk
  // that the controller must not pass through.
  logic [15:0] mem [32];
  logic [15:0] model_rdata;

  always #5 clock = ~clock;

  always_comb mux_data = mem[mux_address];

  can_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .cpu_cs(cpu_cs), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .cpu_err(cpu_err), .mux_address(mux_address),
    .mux_data(mux_data), .reg_we(reg_we), .reg_wdata(reg_wdata), .intr_rd(intr_rd),
    .core_req(core_req), .core_gnt(core_gnt)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    cpu_cs = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  // Model: which strobe a write to address a should produce.
  function automatic logic [20:0] exp_strobe(input logic [4:0] a, input logic w);
    logic [20:0] m;
    m = '0;
    if (w && a >= 5'd7 && a <= 5'd18) m[a] = 1'b1;
    return m;
  endfunction

  // One complete access with cs held until ready, then released.
  task automatic do_access(input logic [4:0] a, input logic w, input logic [15:0] d, input string tag);
    logic [20:0] we_or;
    int we_cycles, intr_cnt, ready_at;
    logic exp_err;
    we_or = '0; we_cycles = 0; intr_cnt = 0; ready_at = -1;
    cpu_cs = 1'b1; cpu_rd = !w; cpu_wr = w; cpu_addr = a; cpu_wdata = d;
    for (int e = 0; e < 10 && ready_at < 0; e++) begin
      step();
      if (reg_we != '0) we_cycles++;
      we_or |= reg_we;
      if (intr_rd) intr_cnt++;
      if (cpu_ready) ready_at = e;
    end
    exp_err = w && !(a >= 5'd7 && a <= 5'd18);
    if (!w) model_rdata = (a <= 5'd20) ? mem[a] : 16'h0000;

    n_cmp++;
    if (ready_at < 2 || ready_at > 3) begin
      n_bad++; $display("FAIL %s latency: ready at edge %0d, required edge 2..3", tag, ready_at);
    end
    n_cmp++;
    if (cpu_err !== exp_err) begin
      n_bad++; $display("FAIL %s err: got %b, required %b", tag, cpu_err, exp_err);
    end
    n_cmp++;
    if (cpu_rdata !== model_rdata) begin
      n_bad++; $display("FAIL %s rdata: got %h, required %h", tag, cpu_rdata, model_rdata);
    end
    n_cmp++;
    if (we_or !== exp_strobe(a, w) || we_cycles !== ((exp_strobe(a, w) != '0) ? 1 : 0)) begin
      n_bad++; $display("FAIL %s strobe: got %h over %0d cycles, required %h", tag, we_or, we_cycles, exp_strobe(a, w));
    end
    n_cmp++;
    if (intr_cnt !== ((!w && a == 5'd18) ? 1 : 0)) begin
      n_bad++; $display("FAIL %s intr_rd: got %0d pulses, required %0d", tag, intr_cnt, (!w && a == 5'd18) ? 1 : 0);
    end
    n_cmp++;
    if (mux_address !== a || reg_wdata !== d) begin
      n_bad++; $display("FAIL %s latch: mux_address %0d wdata %h, required %0d %h", tag, mux_address, reg_wdata, a, d);
    end
    idle_bus();
    step();
    n_cmp++;
    if (cpu_ready !== 1'b0 || cpu_err !== 1'b0) begin
      n_bad++; $display("FAIL %s release: ready %b err %b, required 0 0", tag, cpu_ready, cpu_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_bus(); core_req = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    step(); step();
    n_cmp++;
    if ({cpu_rdata, cpu_ready, cpu_err, reg_we, reg_wdata, mux_address, intr_rd, core_gnt} !== '0) begin
      n_bad++; $display("FAIL reset outputs: rdata %h ready %b err %b we %h wdata %h addr %0d intr %b gnt %b, required all 0",
                        cpu_rdata, cpu_ready, cpu_err, reg_we, reg_wdata, mux_address, intr_rd, core_gnt);
    end
    reset = 1'b0;
    model_rdata = '0;
    step();
  endtask

  task automatic test_read_write();
    do_access(5'd14, 1'b0, 16'h0000, "read14");
    do_access(5'd15, 1'b1, 16'hBEEF, "write15");
    do_access(5'd20, 1'b1, 16'h5A5A, "write20");
    do_access(5'd25, 1'b0, 16'h0000, "read_unmapped");
    do_access(5'd3,  1'b1, 16'h1111, "write_rx");
    do_access(5'd28, 1'b1, 16'h2222, "write_unmapped");
    do_access(5'd7,  1'b1, 16'h3333, "write7");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_access(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 16'($urandom), "random");
    end
  endtask

  task automatic test_intr_and_conflict();
    do_access(5'd18, 1'b0, 16'h0000, "read_intr");
    cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 5'd10; cpu_wdata = 16'hFFFF;
    for (int e = 0; e < 4; e++) begin
      step();
      n_cmp++;
      if (cpu_ready !== 1'b0 || reg_we !== '0) begin
        n_bad++; $display("FAIL rd_wr_both edge %0d: ready %b we %h, required 0 0", e, cpu_ready, reg_we);
      end
    end
    idle_bus();
    step();
  endtask

  task automatic test_core_wait();
    int got;
    core_req = 1'b1;
    step();
    n_cmp++;
    if (core_gnt !== 1'b1) begin
      n_bad++; $display("FAIL core_grant: gnt %b, required 1", core_gnt);
    end
    cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'd3; cpu_wdata = 16'h0;
    for (int e = 0; e < 6; e++) step();
    n_cmp++;
    if (cpu_ready !== 1'b0 || core_gnt !== 1'b1) begin
      n_bad++; $display("FAIL wait_hold: ready %b gnt %b, required 0 1", cpu_ready, core_gnt);
    end
    core_req = 1'b0;
    step();
    n_cmp++;
    if (core_gnt !== 1'b0 || cpu_ready !== 1'b0) begin
      n_bad++; $display("FAIL gnt_drop: gnt %b ready %b, required 0 0", core_gnt, cpu_ready);
    end
    step(); step();
    got = cpu_ready;
    n_cmp++;
    if (got !== 1 || cpu_rdata !== mem[3]) begin
      n_bad++; $display("FAIL wait_complete: ready %0d rdata %h, required 1 %h", got, cpu_rdata, mem[3]);
    end
    model_rdata = mem[3];
    idle_bus();
    step();
  endtask

  task automatic test_same_edge();
    int ready_at;
    core_req = 1'b1;
    cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'd5;
    step();
    n_cmp++;
    if (core_gnt !== 1'b1) begin
      n_bad++; $display("FAIL same_edge gnt: %b, required 1", core_gnt);
    end
    for (int e = 0; e < 4; e++) step();
    n_cmp++;
    if (cpu_ready !== 1'b0) begin
      n_bad++; $display("FAIL same_edge cpu_wait: ready %b, required 0", cpu_ready);
    end
    core_req = 1'b0;
    ready_at = -1;
    for (int e = 0; e < 10 && ready_at < 0; e++) begin
      step();
      if (cpu_ready) ready_at = e;
    end
    n_cmp++;
    if (ready_at < 0 || cpu_rdata !== mem[5]) begin
      n_bad++; $display("FAIL same_edge complete: ready at %0d rdata %h, required done %h", ready_at, cpu_rdata, mem[5]);
    end
    model_rdata = mem[5];
    idle_bus();
    step();
  endtask

  // core_req arrives while the CPU is in ACCESS; for receive addresses the
  // grant slips one cycle, for other addresses it does not.
  task automatic test_deferred_grant(input logic [4:0] a, input logic deferred);
    cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = a;
    step();  // edge 0: CHECK
    step();  // edge 1: ACCESS
    core_req = 1'b1;
    step();  // edge 2: request sampled during ACCESS
    n_cmp++;
    if (core_gnt !== !deferred) begin
      n_bad++; $display("FAIL defer addr %0d edge2: gnt %b, required %b", a, core_gnt, !deferred);
    end
    step();
    n_cmp++;
    if (core_gnt !== 1'b1 || cpu_ready !== 1'b1 || cpu_rdata !== mem[a]) begin
      n_bad++; $display("FAIL defer addr %0d edge3: gnt %b ready %b rdata %h, required 1 1 %h",
                        a, core_gnt, cpu_ready, cpu_rdata, mem[a]);
    end
    model_rdata = mem[a];
    core_req = 1'b0;
    idle_bus();
    step(); step();
  endtask

  task automatic test_cs_early_drop();
    cpu_cs = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 5'd9; cpu_wdata = 16'hC0DE;
    step();
    idle_bus();
    step();
    n_cmp++;
    if (reg_we !== 21'(1 << 9)) begin
      n_bad++; $display("FAIL early_drop strobe: %h, required %h", reg_we, 21'(1 << 9));
    end
    step();
    n_cmp++;
    if (cpu_ready !== 1'b1) begin
      n_bad++; $display("FAIL early_drop done: ready %b, required 1", cpu_ready);
    end
    step();
    n_cmp++;
    if (cpu_ready !== 1'b0) begin
      n_bad++; $display("FAIL early_drop exit: ready %b, required 0", cpu_ready);
    end
  endtask

  task automatic test_reset_in_wait();
    do_access(5'd14, 1'b0, 16'h0000, "pre_reset_read");
    core_req = 1'b1;
    step();
    cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'd4; cpu_wdata = 16'h9876;
    step(); step(); step();
    reset = 1'b1;
    step();
    n_cmp++;
    if ({cpu_rdata, cpu_ready, cpu_err, reg_we, reg_wdata, mux_address, intr_rd, core_gnt} !== '0) begin
      n_bad++; $display("FAIL reset_in_wait: rdata %h ready %b err %b we %h wdata %h addr %0d intr %b gnt %b, required all 0",
                        cpu_rdata, cpu_ready, cpu_err, reg_we, reg_wdata, mux_address, intr_rd, core_gnt);
    end
    reset = 1'b0; core_req = 1'b0; idle_bus();
    model_rdata = '0;
    step();
  endtask

`ifdef CAN_BUS_TIMEOUT_EN
  task automatic test_timeout();
    int ready_at;
    logic [20:0] we_or;
    do_access(5'd14, 1'b0, 16'h0000, "pre_timeout_read");
    core_req = 1'b1;
    step();
    cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'd0;
    ready_at = -1; we_or = '0;
    for (int e = 0; e < 20 && ready_at < 0; e++) begin
      step();
      we_or |= reg_we;
      if (cpu_ready) ready_at = e;
    end
    n_cmp++;
    if (ready_at < 0 || cpu_err !== 1'b1 || cpu_rdata !== 16'h0000 || we_or !== '0) begin
      n_bad++; $display("FAIL timeout: ready at %0d err %b rdata %h we %h, required done 1 0000 0",
                        ready_at, cpu_err, cpu_rdata, we_or);
    end
    model_rdata = 16'h0000;
    core_req = 1'b0; idle_bus();
    step(); step();
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    mem[14] = 16'h1234;
    mem[25] = 16'hDEAD;
    test_reset();
    test_read_write();
    test_intr_and_conflict();
    test_core_wait();
    test_same_edge();
    test_deferred_grant(5'd2, 1'b1);
    test_deferred_grant(5'd14, 1'b0);
    test_cs_early_drop();
    test_random();
    test_reset_in_wait();
`ifdef CAN_BUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
